// File: rtl/lcd_tile_write_arbiter.sv
// Vblank-gated, budget-limited arbiter sharing the tile-colour RAM write port between requesters A and B.
// Optional macro ARB_FIXED_PRIO_EN: A always wins contention (no round-robin pointer).
module lcd_tile_write_arbiter #(
    parameter int TILES_X = 60,
    parameter int TILES_Y = 34,
    parameter int COLOR_W = 16,
    parameter int BUDGET  = 64
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_frame_start,
    input  logic               in_vblank,
    input  logic               in_a_valid,
    output logic               out_a_ready,
    input  logic [5:0]         in_a_x,
    input  logic [5:0]         in_a_y,
    input  logic [COLOR_W-1:0] in_a_color,
    input  logic               in_b_valid,
    output logic               out_b_ready,
    input  logic [5:0]         in_b_x,
    input  logic [5:0]         in_b_y,
    input  logic [COLOR_W-1:0] in_b_color,
    output logic               out_we,
    output logic [10:0]        out_waddr,
    output logic [COLOR_W-1:0] out_wdata,
    output logic [7:0]         out_budget_left,
    output logic [7:0]         out_drop_count
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        OPEN       = 2'd1,
        EXHAUSTED  = 2'd2
    } state_t;

    localparam logic [7:0]  BUDGET_L = 8'(BUDGET);
    localparam logic [5:0]  X_LIM    = 6'(TILES_X);
    localparam logic [5:0]  Y_LIM    = 6'(TILES_Y);
    localparam logic [10:0] X_MUL    = 11'(TILES_X);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_budget;
    logic [7:0]           r_drop;
    logic                 r_we;
    logic [10:0]          r_waddr;
    logic [COLOR_W-1:0]   r_wdata;

    logic                 w_grant_ok;
    logic                 w_a_rdy;
    logic                 w_b_rdy;
    logic                 w_xfer;
    logic                 w_legal;
    logic [5:0]           w_x;
    logic [5:0]           w_y;
    logic [COLOR_W-1:0]   w_color;
    logic [10:0]          w_addr;
    logic [7:0]           w_budget_base;

`ifndef ARB_FIXED_PRIO_EN
    logic                 r_ptr_b;
`endif

    // State register
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= WAIT_FRAME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; exhaustion is seen one cycle after the budget hits zero
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_FRAME: begin
                if (in_frame_start) w_state_nxt = OPEN;
                else                w_state_nxt = WAIT_FRAME;
            end
            OPEN: begin
                if (in_frame_start)          w_state_nxt = OPEN;
                else if (r_budget == 8'd0)   w_state_nxt = EXHAUSTED;
                else                         w_state_nxt = OPEN;
            end
            EXHAUSTED: begin
                if (in_frame_start) w_state_nxt = OPEN;
                else                w_state_nxt = EXHAUSTED;
            end
            default: w_state_nxt = WAIT_FRAME;
        endcase
    end

    // Output logic: grants, winner mux and address computation
    always_comb begin
        w_grant_ok = (r_state == OPEN) && in_vblank && (r_budget != 8'd0);
`ifdef ARB_FIXED_PRIO_EN
        w_a_rdy = w_grant_ok && in_a_valid;
        w_b_rdy = w_grant_ok && in_b_valid && !in_a_valid;
`else
        w_a_rdy = w_grant_ok && in_a_valid && (!in_b_valid || !r_ptr_b);
        w_b_rdy = w_grant_ok && in_b_valid && (!in_a_valid || r_ptr_b);
`endif
        w_xfer = w_a_rdy || w_b_rdy;
        if (w_b_rdy) begin
            w_x     = in_b_x;
            w_y     = in_b_y;
            w_color = in_b_color;
        end else begin
            w_x     = in_a_x;
            w_y     = in_a_y;
            w_color = in_a_color;
        end
        w_legal       = (w_x < X_LIM) && (w_y < Y_LIM);
        w_addr        = 11'(w_y) * X_MUL + 11'(w_x);
        // Reload takes effect before a coincident legal transfer is charged
        w_budget_base = in_frame_start ? BUDGET_L : r_budget;
    end

    // Write path, budget and drop counter
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_we     <= 1'b0;
            r_waddr  <= 11'd0;
            r_wdata  <= '0;
            r_budget <= 8'd0;
            r_drop   <= 8'd0;
        end else begin
            r_we <= w_xfer && w_legal;
            if (w_xfer && w_legal) begin
                r_waddr  <= w_addr;
                r_wdata  <= w_color;
                r_budget <= w_budget_base - 8'd1;
            end else begin
                r_budget <= w_budget_base;
            end
            if (w_xfer && !w_legal && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Round-robin pointer flips only after a contended transfer
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_ptr_b <= 1'b0;
        end else if (in_a_valid && in_b_valid && w_xfer) begin
            r_ptr_b <= !r_ptr_b;
        end
    end
`endif

    assign out_a_ready     = w_a_rdy;
    assign out_b_ready     = w_b_rdy;
    assign out_we          = r_we;
    assign out_waddr       = r_waddr;
    assign out_wdata       = r_wdata;
    assign out_budget_left = r_budget;
    assign out_drop_count  = r_drop;

endmodule

// File: tb/tb_lcd_tile_write_arbiter.sv
// Directed bench: two arbiters (BUDGET=64 and BUDGET=4) share one stimulus stream.
module tb_lcd_tile_write_arbiter;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic        in_frame_start = 1'b0;
    logic        in_vblank = 1'b0;
    logic        in_a_valid = 1'b0;
    logic [5:0]  in_a_x = 6'd0;
    logic [5:0]  in_a_y = 6'd0;
    logic [15:0] in_a_color = 16'd0;
    logic        in_b_valid = 1'b0;
    logic [5:0]  in_b_x = 6'd0;
    logic [5:0]  in_b_y = 6'd0;
    logic [15:0] in_b_color = 16'd0;

    logic        a_rdy, b_rdy, we;
    logic [10:0] waddr;
    logic [15:0] wdata;
    logic [7:0]  budget, drops;
    logic        a_rdy4, b_rdy4, we4;
    logic [10:0] waddr4;
    logic [15:0] wdata4;
    logic [7:0]  budget4, drops4;

    int checks = 0;
    int errors = 0;

    lcd_tile_write_arbiter #(.BUDGET(64)) u_dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_frame_start(in_frame_start), .in_vblank(in_vblank),
        .in_a_valid(in_a_valid), .out_a_ready(a_rdy), .in_a_x(in_a_x), .in_a_y(in_a_y), .in_a_color(in_a_color),
        .in_b_valid(in_b_valid), .out_b_ready(b_rdy), .in_b_x(in_b_x), .in_b_y(in_b_y), .in_b_color(in_b_color),
        .out_we(we), .out_waddr(waddr), .out_wdata(wdata), .out_budget_left(budget), .out_drop_count(drops)
    );

    lcd_tile_write_arbiter #(.BUDGET(4)) u_dut4 (
        .in_clk(in_clk), .in_rst(in_rst), .in_frame_start(in_frame_start), .in_vblank(in_vblank),
        .in_a_valid(in_a_valid), .out_a_ready(a_rdy4), .in_a_x(in_a_x), .in_a_y(in_a_y), .in_a_color(in_a_color),
        .in_b_valid(in_b_valid), .out_b_ready(b_rdy4), .in_b_x(in_b_x), .in_b_y(in_b_y), .in_b_color(in_b_color),
        .out_we(we4), .out_waddr(waddr4), .out_wdata(wdata4), .out_budget_left(budget4), .out_drop_count(drops4)
    );

    always #5 in_clk = ~in_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        int n;
        // Reset state
        step();
        step();
        check_eq("rst_we", 32'(we), 32'd0);
        check_eq("rst_waddr", 32'(waddr), 32'd0);
        check_eq("rst_wdata", 32'(wdata), 32'd0);
        check_eq("rst_budget", 32'(budget), 32'd0);
        check_eq("rst_drop", 32'(drops), 32'd0);
        in_rst = 1'b1;

        // No grant before the first frame_start
        in_a_valid = 1'b1; in_a_x = 6'd3; in_a_y = 6'd2; in_a_color = 16'hF800; in_vblank = 1'b1;
        #1;
        check_eq("wait_rdy", 32'(a_rdy), 32'd0);
        step();
        check_eq("wait_we", 32'(we), 32'd0);
        check_eq("wait_rdy2", 32'(a_rdy), 32'd0);
        in_frame_start = 1'b1;
        step();
        in_frame_start = 1'b0;
        #1;
        check_eq("s1_rdy", 32'(a_rdy), 32'd1);
        step();
        in_a_valid = 1'b0;
        check_eq("s1_we", 32'(we), 32'd1);
        check_eq("s1_waddr", 32'(waddr), 32'd123);
        check_eq("s1_wdata", 32'(wdata), 32'hF800);
        check_eq("s1_budget", 32'(budget), 32'd63);

        // Contention: round robin (or fixed priority)
        in_a_valid = 1'b1; in_a_x = 6'd1; in_a_y = 6'd0; in_a_color = 16'h00AA;
        in_b_valid = 1'b1; in_b_x = 6'd2; in_b_y = 6'd0; in_b_color = 16'h00BB;
        #1;
        for (int k = 0; k < 6; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            check_eq("rr_a_rdy", 32'(a_rdy), 32'd1);
            check_eq("rr_b_rdy", 32'(b_rdy), 32'd0);
            step();
            check_eq("rr_waddr", 32'(waddr), 32'd1);
`else
            check_eq("rr_a_rdy", 32'(a_rdy), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_b_rdy", 32'(b_rdy), (k % 2 == 0) ? 32'd0 : 32'd1);
            step();
            check_eq("rr_waddr", 32'(waddr), (k % 2 == 0) ? 32'd1 : 32'd2);
`endif
            check_eq("rr_we", 32'(we), 32'd1);
        end
        in_a_valid = 1'b0;
        check_eq("rr_budget", 32'(budget), 32'd57);

        // Out-of-range requests: accepted, dropped, saturating counter
        in_b_x = 6'd60; in_b_y = 6'd0;
        #1;
        check_eq("oor_rdy", 32'(b_rdy), 32'd1);
        step();
        check_eq("oor_we", 32'(we), 32'd0);
        check_eq("oor_drop1", 32'(drops), 32'd1);
        check_eq("oor_budget", 32'(budget), 32'd57);
        for (int k = 1; k < 300; k++) step();
        check_eq("oor_drop_sat", 32'(drops), 32'd255);
        check_eq("oor_waddr_hold", 32'(waddr), 32'd2);
        in_b_x = 6'd0; in_b_y = 6'd34;
        step();
        check_eq("oor_y_drop", 32'(drops), 32'd255);
        check_eq("oor_y_we", 32'(we), 32'd0);
        in_b_valid = 1'b0;

        // Budget exhaustion on the BUDGET=4 instance
        in_frame_start = 1'b1;
        step();
        in_frame_start = 1'b0;
        check_eq("b4_load", 32'(budget4), 32'd4);
        in_a_valid = 1'b1; in_a_x = 6'd5; in_a_y = 6'd1; in_a_color = 16'h1234;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (we4) n++;
        end
        check_eq("b4_writes", 32'(n), 32'd4);
        check_eq("b4_waddr", 32'(waddr4), 32'd65);
        check_eq("b4_budget0", 32'(budget4), 32'd0);
        check_eq("b4_exh_rdy", 32'(a_rdy4), 32'd0);
        in_frame_start = 1'b1;
        #1;
        check_eq("b4_exh_fs_rdy", 32'(a_rdy4), 32'd0);
        step();
        in_frame_start = 1'b0;
        check_eq("b4_reload", 32'(budget4), 32'd4);
        check_eq("b4_resume_rdy", 32'(a_rdy4), 32'd1);
        step();
        check_eq("b4_resume_we", 32'(we4), 32'd1);
        check_eq("b4_resume_bud", 32'(budget4), 32'd3);
        step();
        step();
        check_eq("b4_bud1", 32'(budget4), 32'd1);

        // frame_start coincident with a transfer at budget 1
        in_frame_start = 1'b1;
        #1;
        check_eq("fs_xfer_rdy", 32'(a_rdy4), 32'd1);
        step();
        in_frame_start = 1'b0;
        in_a_valid = 1'b0;
        check_eq("fs_xfer_we", 32'(we4), 32'd1);
        check_eq("fs_xfer_bud", 32'(budget4), 32'd3);

        // vblank low: no grants
        in_vblank = 1'b0; in_a_valid = 1'b1;
        #1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (a_rdy4 || a_rdy) n++;
            step();
            if (we4) n++;
        end
        check_eq("novb_grants", 32'(n), 32'd0);
        check_eq("novb_bud", 32'(budget4), 32'd3);
        in_vblank = 1'b1;
        #1;
        check_eq("vb_rdy", 32'(a_rdy4), 32'd1);

        // Reset asserted in the cycle of a transfer
        #2;
        in_rst = 1'b0;
        step();
        check_eq("rr_rst_we", 32'(we4), 32'd0);
        check_eq("rr_rst_waddr", 32'(waddr4), 32'd0);
        check_eq("rr_rst_wdata", 32'(wdata4), 32'd0);
        check_eq("rr_rst_bud", 32'(budget4), 32'd0);
        check_eq("rr_rst_drop", 32'(drops), 32'd0);
        check_eq("rr_rst_rdy", 32'(a_rdy4), 32'd0);
        in_rst = 1'b1;
        #1;
        check_eq("post_rst_rdy", 32'(a_rdy4 | a_rdy), 32'd0);
        step();
        check_eq("post_rst_we", 32'(we4 | we), 32'd0);
        check_eq("post_rst_rdy2", 32'(a_rdy4 | a_rdy), 32'd0);
        in_a_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
